// File: rtl/fpu_mul_param_if.sv
// Handshake bundle for fpu_mul_param: operand request channel plus result/flag channel.
interface fpu_mul_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic [W-1:0] din1;
    logic [W-1:0] din2;
    logic [2:0]   rm;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] result;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   flags;

    modport master (
        output din1, din2, rm, in_valid, out_ready,
        input  in_ready, result, out_valid, flags
    );

    modport slave (
        input  din1, din2, rm, in_valid, out_ready,
        output in_ready, result, out_valid, flags
    );
endinterface

// File: rtl/fpu_mul_param.sv
// Multi-cycle parameterised IEEE-754 multiplier: one operation in flight, fields
// unpacked, normalised, multiplied, denormalised, rounded and packed by a sequencer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for in_valid; operands and rm captured on accept
// UNPACK  | split operands into significand / unbiased exponent
// SPECIAL | NaN / inf / zero operands resolved here, straight to OUT
// NORM_A  | shift subnormal significand A up to its hidden bit
// NORM_B  | shift subnormal significand B up to its hidden bit
// MULT    | full significand product, exponent ea+eb+1
// NORM    | shift product until its MSB is set
// DENORM  | right-shift into subnormal range, collecting sticky
// ROUND   | apply rounding mode, carry-out bumps exponent
// PACK    | overflow/underflow resolution, build result and flags
// OUT     | result held until out_ready
module fpu_mul_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic           clk,
    input  logic           reset,
    fpu_mul_param_if.slave bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EW   = EXP_W + 2;
    localparam int SW   = MAN_W + 1;
    localparam int PW   = 2 * SW;
    localparam int BIAS = 2**(EXP_W-1) - 1;

    localparam logic signed [EW-1:0] C_BIAS = EW'(BIAS);
    localparam logic signed [EW-1:0] C_EMIN = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] C_ONE  = EW'(1);
    localparam logic [EW-1:0]        C_PW   = EW'(PW);
    localparam logic [W-1:0]         C_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE, S_UNPACK, S_SPECIAL, S_NORM_A, S_NORM_B, S_MULT,
        S_NORM, S_DENORM, S_ROUND, S_PACK, S_OUT
    } state_t;

    state_t r_state, w_next;

    logic [W-1:0]          r_a, r_b;
    logic [2:0]            r_rm;
    logic [SW-1:0]         r_sa, r_sb, r_rsig;
    logic signed [EW-1:0]  r_ea, r_eb, r_exp;
    logic [PW-1:0]         r_prod;
    logic                  r_sticky, r_inexact;
    logic [W-1:0]          r_result;
    logic [4:0]            r_flags;

    logic [EXP_W-1:0]      w_a_exp, w_b_exp;
    logic [MAN_W-1:0]      w_a_frac, w_b_frac;
    logic                  w_a_ezero, w_b_ezero, w_a_emax, w_b_emax;
    logic                  w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic                  w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic                  w_sign, w_special;
    logic signed [EW-1:0]  w_a_eunb, w_b_eunb;
    logic [W-1:0]          w_spec_res;
    logic [4:0]            w_spec_flags;

    assign w_a_exp   = r_a[W-2 -: EXP_W];
    assign w_b_exp   = r_b[W-2 -: EXP_W];
    assign w_a_frac  = r_a[MAN_W-1:0];
    assign w_b_frac  = r_b[MAN_W-1:0];
    assign w_a_ezero = ~|w_a_exp;
    assign w_b_ezero = ~|w_b_exp;
    assign w_a_emax  = &w_a_exp;
    assign w_b_emax  = &w_b_exp;
    assign w_a_nan   = w_a_emax & (|w_a_frac);
    assign w_b_nan   = w_b_emax & (|w_b_frac);
    assign w_a_snan  = w_a_nan & ~w_a_frac[MAN_W-1];
    assign w_b_snan  = w_b_nan & ~w_b_frac[MAN_W-1];
    assign w_a_inf   = w_a_emax & ~(|w_a_frac);
    assign w_b_inf   = w_b_emax & ~(|w_b_frac);
    assign w_a_zero  = w_a_ezero & ~(|w_a_frac);
    assign w_b_zero  = w_b_ezero & ~(|w_b_frac);
    assign w_sign    = r_a[W-1] ^ r_b[W-1];
    assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;

    // Subnormals start at the minimum exponent with hidden bit 0.
    assign w_a_eunb = w_a_ezero ? C_EMIN : ($signed(EW'(w_a_exp)) - C_BIAS);
    assign w_b_eunb = w_b_ezero ? C_EMIN : ($signed(EW'(w_b_exp)) - C_BIAS);

    always_comb begin
        w_spec_res   = C_QNAN;
        w_spec_flags = '0;
        if (w_a_nan | w_b_nan) begin
            w_spec_flags[4] = w_a_snan | w_b_snan;
        end else if ((w_a_inf & w_b_zero) | (w_b_inf & w_a_zero)) begin
            w_spec_flags[4] = 1'b1;
        end else if (w_a_inf | w_b_inf) begin
            w_spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            w_spec_res = {w_sign, {(W-1){1'b0}}};
        end
    end

    // Single-cycle denormalisation keeps the worst-case latency bounded.
    logic            w_dn_need, w_dn_lost;
    logic [EW-1:0]   w_dn_amt, w_dn_amt_c;
    logic [PW-1:0]   w_dn_shifted;

    assign w_dn_need    = r_exp < C_EMIN;
    assign w_dn_amt     = C_EMIN - r_exp;
    assign w_dn_amt_c   = (w_dn_amt > C_PW) ? C_PW : w_dn_amt;
    assign w_dn_shifted = r_prod >> w_dn_amt_c;
    assign w_dn_lost    = (w_dn_shifted << w_dn_amt_c) != r_prod;

    logic [SW-1:0]   w_kept;
    logic            w_g, w_r, w_s, w_inc;
    logic [SW:0]     w_sum;

    assign w_kept = r_prod[PW-1 -: SW];
    assign w_g    = r_prod[MAN_W];
    assign w_r    = r_prod[MAN_W-1];
    assign w_s    = (|r_prod[MAN_W-2:0]) | r_sticky;
    assign w_sum  = {1'b0, w_kept} + (SW+1)'(w_inc);

    always_comb begin
        w_inc = 1'b0;
        case (r_rm)
            3'd1:    w_inc = 1'b0;
            3'd2:    w_inc = w_sign & (w_g | w_r | w_s);
            3'd3:    w_inc = ~w_sign & (w_g | w_r | w_s);
            3'd4:    w_inc = w_g;
            default: w_inc = w_g & (w_r | w_s | w_kept[0]);
        endcase
    end

    logic             w_ovf, w_tiny, w_ovf_inf;
    logic [EXP_W-1:0] w_efield;
    logic [W-1:0]     w_pack_res;
    logic [4:0]       w_pack_flags;

    assign w_ovf    = r_exp > C_BIAS;
    assign w_tiny   = ~r_rsig[MAN_W];
    assign w_efield = w_tiny ? '0 : EXP_W'(r_exp + C_BIAS);

    always_comb begin
        w_ovf_inf = 1'b1;
        case (r_rm)
            3'd1:    w_ovf_inf = 1'b0;
            3'd2:    w_ovf_inf = w_sign;
            3'd3:    w_ovf_inf = ~w_sign;
            default: w_ovf_inf = 1'b1;
        endcase
    end

    always_comb begin
        w_pack_res = {w_sign, w_efield, r_rsig[MAN_W-1:0]};
        if (w_ovf) begin
            if (w_ovf_inf) w_pack_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else           w_pack_res = {w_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end
    end

    assign w_pack_flags = {2'b00, w_ovf, ~w_ovf & w_tiny & r_inexact, w_ovf | r_inexact};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Shift loops exit on the cycle whose shift lands the leading one in place.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.in_valid) w_next = S_UNPACK;
            S_UNPACK:  w_next = S_SPECIAL;
            S_SPECIAL: w_next = w_special ? S_OUT : S_NORM_A;
            S_NORM_A:  if (r_sa[MAN_W] | r_sa[MAN_W-1]) w_next = S_NORM_B;
            S_NORM_B:  if (r_sb[MAN_W] | r_sb[MAN_W-1]) w_next = S_MULT;
            S_MULT:    w_next = S_NORM;
            S_NORM:    if (r_prod[PW-1] | r_prod[PW-2]) w_next = S_DENORM;
            S_DENORM:  w_next = S_ROUND;
            S_ROUND:   w_next = S_PACK;
            S_PACK:    w_next = S_OUT;
            S_OUT:     if (bus.out_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_rm      <= '0;
            r_sa      <= '0;
            r_sb      <= '0;
            r_rsig    <= '0;
            r_ea      <= '0;
            r_eb      <= '0;
            r_exp     <= '0;
            r_prod    <= '0;
            r_sticky  <= 1'b0;
            r_inexact <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a  <= bus.din1;
                        r_b  <= bus.din2;
                        r_rm <= bus.rm;
                    end
                end
                S_UNPACK: begin
                    r_sa <= {~w_a_ezero, w_a_frac};
                    r_sb <= {~w_b_ezero, w_b_frac};
                    r_ea <= w_a_eunb;
                    r_eb <= w_b_eunb;
                end
                S_SPECIAL: begin
                    if (w_special) begin
                        r_result <= w_spec_res;
                        r_flags  <= w_spec_flags;
                    end
                end
                S_NORM_A: begin
                    if (!r_sa[MAN_W]) begin
                        r_sa <= r_sa << 1;
                        r_ea <= r_ea - C_ONE;
                    end
                end
                S_NORM_B: begin
                    if (!r_sb[MAN_W]) begin
                        r_sb <= r_sb << 1;
                        r_eb <= r_eb - C_ONE;
                    end
                end
                S_MULT: begin
                    r_prod   <= PW'(r_sa) * PW'(r_sb);
                    r_exp    <= r_ea + r_eb + C_ONE;
                    r_sticky <= 1'b0;
                end
                S_NORM: begin
                    if (!r_prod[PW-1]) begin
                        r_prod <= r_prod << 1;
                        r_exp  <= r_exp - C_ONE;
                    end
                end
                S_DENORM: begin
                    if (w_dn_need) begin
                        r_prod   <= w_dn_shifted;
                        r_sticky <= r_sticky | w_dn_lost;
                        r_exp    <= C_EMIN;
                    end
                end
                S_ROUND: begin
                    r_inexact <= w_g | w_r | w_s;
                    if (w_sum[SW]) begin
                        r_rsig <= w_sum[SW:1];
                        r_exp  <= r_exp + C_ONE;
                    end else begin
                        r_rsig <= w_sum[SW-1:0];
                    end
                end
                S_PACK: begin
                    r_result <= w_pack_res;
                    r_flags  <= w_pack_flags;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;
endmodule

// File: tb/tb_fpu_mul_param.sv
// Directed bench for fpu_mul_param: binary32 and binary16-shaped instances,
// hand-computed products, flags and cycle counts.
module tb_fpu_mul_param;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    fpu_mul_param_if #(.EXP_W(8), .MAN_W(23)) bus32();
    fpu_mul_param_if #(.EXP_W(5), .MAN_W(10)) bus16();

    fpu_mul_param #(.EXP_W(8), .MAN_W(23)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    fpu_mul_param #(.EXP_W(5), .MAN_W(10)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    endtask

    // exp_lat > 0 demands that exact latency, otherwise only the worst-case bound.
    task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] rm, input logic [31:0] exp_res,
                        input logic [4:0] exp_fl, input int exp_lat, input int hold);
        int lat;
        bus32.din1     = a;
        bus32.din2     = b;
        bus32.rm       = rm;
        bus32.in_valid = 1'b1;
        check_val({tag, ".rdy"}, bus32.in_ready, 1);
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        bus32.din1     = ~a;
        bus32.din2     = ~b;
        bus32.rm       = 3'd3;
        lat = 0;
        while (!bus32.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, ".vld"}, bus32.out_valid, 1);
        if (exp_lat > 0) check_val({tag, ".lat"}, lat, exp_lat);
        else             check_val({tag, ".latmax"}, (lat <= 2*23+12), 1);
        check_val({tag, ".res"}, bus32.result, exp_res);
        check_val({tag, ".flg"}, bus32.flags, exp_fl);
        for (int i = 0; i < hold; i++) begin
            bus32.in_valid = 1'b1;
            bus32.din1     = 32'h3F800000;
            bus32.din2     = 32'h40000000;
            @(posedge clk); #1;
            check_val({tag, ".hold_res"}, bus32.result, exp_res);
            check_val({tag, ".hold_rdy"}, bus32.in_ready, 0);
            check_val({tag, ".hold_vld"}, bus32.out_valid, 1);
        end
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
        check_val({tag, ".done"}, bus32.out_valid, 0);
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] rm, input logic [15:0] exp_res,
                        input logic [4:0] exp_fl, input int exp_lat);
        int lat;
        bus16.din1     = a;
        bus16.din2     = b;
        bus16.rm       = rm;
        bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        bus16.din1     = ~a;
        bus16.din2     = ~b;
        lat = 0;
        while (!bus16.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, ".lat"}, lat, exp_lat);
        check_val({tag, ".res"}, bus16.result, exp_res);
        check_val({tag, ".flg"}, bus16.flags, exp_fl);
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus32.din1      = '0;
        bus32.din2      = '0;
        bus32.rm        = '0;
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b0;
        bus16.din1      = '0;
        bus16.din2      = '0;
        bus16.rm        = '0;
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b0;
        #12;
        reset = 1'b0;
        check_val("rst.rdy", bus32.in_ready, 1);
        check_val("rst.vld", bus32.out_valid, 0);
        check_val("rst.res", bus32.result, 0);
        check_val("rst.flg", bus32.flags, 0);

        op32("mul2x3",      32'h40000000, 32'h40400000, 3'd0, 32'h40C00000, 5'b00000, 9, 0);
        op32("inf_x_zero",  32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b10000, 0, 0);
        op32("snan",        32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b10000, 0, 0);
        op32("qnan",        32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b00000, 0, 0);
        op32("ovf_rne",     32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 5'b00101, 9, 0);
        op32("ovf_rtz",     32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 5'b00101, 9, 0);
        op32("ovf_rdn_neg", 32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 5'b00101, 9, 0);
        op32("ovf_rup_neg", 32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 5'b00101, 9, 0);
        op32("tie_rne",     32'h00000001, 32'h3F000000, 3'd0, 32'h00000000, 5'b00011, 0, 0);
        op32("tie_rup",     32'h00000001, 32'h3F000000, 3'd3, 32'h00000001, 5'b00011, 0, 0);
        op32("tie_rmm",     32'h00000001, 32'h3F000000, 3'd4, 32'h00000001, 5'b00011, 0, 0);
        op32("sub_exact",   32'h00000001, 32'h3F800000, 3'd0, 32'h00000001, 5'b00000, 0, 0);
        op32("inf_x_neg",   32'h7F800000, 32'hC0000000, 3'd0, 32'hFF800000, 5'b00000, 0, 0);
        op32("zero_x_neg",  32'h00000000, 32'hC0400000, 3'd0, 32'h80000000, 5'b00000, 0, 0);
        op32("inx_rne",     32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 5'b00001, 9, 0);
        op32("inx_rup",     32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 5'b00001, 9, 0);
        op32("hold",        32'h3FC00000, 32'h3FC00000, 3'd0, 32'h40100000, 5'b00000, 9, 5);

        // Abort a long subnormal operation while it is still in NORM_A.
        bus32.din1     = 32'h00000001;
        bus32.din2     = 32'h3F800000;
        bus32.rm       = 3'd0;
        bus32.in_valid = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check_val("midrst.vld", bus32.out_valid, 0);
        check_val("midrst.rdy", bus32.in_ready, 1);
        check_val("midrst.res", bus32.result, 0);
        check_val("midrst.flg", bus32.flags, 0);
        reset = 1'b0;
        op32("post_rst",    32'h40000000, 32'h40400000, 3'd0, 32'h40C00000, 5'b00000, 9, 0);

        op16("h_mul2x3",    16'h4000, 16'h4200, 3'd0, 16'h4600, 5'b00000, 9);
        op16("h_ovf",       16'h7BFF, 16'h4000, 3'd0, 16'h7C00, 5'b00101, 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fpu_mul_param.md
FPU_MUL_PARAM -- requirements
Module: fpu_mul_param

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (legal 5..11).
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (legal 10..52); W = 1+EXP_W+MAN_W, BIAS = 2^(EXP_W-1)-1.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; ports: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 din1, din2  input  W each  IEEE-754 operands, packed {sign, exp, frac}.
REQ-006 rm  input  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5..7 treated as RNE.
REQ-007 in_valid  input  1  operand request; in_ready  output  1  block can accept.
REQ-008 result  output  W  product; out_valid  output  1  result/flags valid; out_ready  input  1  consumer accepts.
REQ-009 flags  output  5  {invalid, divzero(always 0), overflow, underflow, inexact}.

Function
REQ-010 SHALL capture din1, din2, rm on a clk edge where in_valid && in_ready; in_ready SHALL be 1 only in IDLE.
REQ-011 FSM states: IDLE, UNPACK, SPECIAL, NORM_A, NORM_B, MULT, NORM, DENORM, ROUND, PACK, OUT.
REQ-012 IDLE->UNPACK on accept; UNPACK->SPECIAL; SPECIAL->OUT for NaN/inf/zero operands, else ->NORM_A.
REQ-013 NORM_A/NORM_B SHALL shift subnormal significands left one bit per cycle until the hidden bit is 1, decrementing exponent; normal operands pass in one cycle.
REQ-014 MULT SHALL form full (MAN_W+1)x(MAN_W+1) product and exponent ea+eb+1 in an internal signed exponent of EXP_W+2 bits.
REQ-015 NORM SHALL left-shift until product MSB is 1; DENORM SHALL right-shift while exponent < 1-BIAS, OR-ing shifted-out bits into sticky.
REQ-016 ROUND SHALL increment per rm using guard, round, sticky, LSB and sign; carry-out SHALL increment exponent.
REQ-017 Overflow (exponent > BIAS after round): RNE/RMM -> +/-inf; RTZ -> max finite; RDN -> max finite if positive, -inf if negative; RUP -> +inf if positive, max finite if negative; set overflow and inexact.
REQ-018 Subnormal/zero result SHALL pack exponent field 0; underflow SHALL set when result is tiny after rounding and inexact.
REQ-019 inexact SHALL set when any of guard/round/sticky is nonzero at ROUND.
REQ-020 Any NaN operand, or inf x 0, SHALL return canonical qNaN: sign 0, exp all ones, frac MSB 1, rest 0.
REQ-021 invalid SHALL set for signalling NaN input (frac MSB 0, frac != 0) or inf x 0; quiet NaN input SHALL not set invalid.
REQ-022 inf x finite-nonzero SHALL return inf, sign = XOR; zero x finite SHALL return zero, sign = XOR; flags 0.
REQ-023 Worst-case latency accept->out_valid SHALL not exceed 2*MAN_W+12 cycles; normal x normal without underflow SHALL take exactly 9 cycles.
REQ-024 In OUT, out_valid=1 and result/flags SHALL hold stable until out_ready=1; on that edge go IDLE, out_valid=0 next cycle.
REQ-025 in_valid asserted while busy SHALL be ignored (no capture, no state change); input changes after capture SHALL not affect the result.
REQ-026 rm SHALL be sampled only at accept.

Reset
REQ-027 Asserting reset SHALL immediately force state IDLE, out_valid=0, flags=0, result=0, in_ready=1 after deassertion, regardless of operation in progress.
REQ-028 First accept after reset deassertion SHALL be possible on the first clk edge.

Verification
REQ-029 Default params, RNE: 0x40000000 x 0x40400000 -> result 0x40C00000, flags 0, out_valid 9 cycles after accept.
REQ-030 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1; 0x7F800001 x 0x3F800000 -> 0x7FC00000, invalid=1.
REQ-031 0x7F7FFFFF x 0x40000000: RNE -> 0x7F800000, RTZ -> 0x7F7FFFFF, RDN with din1=0xFF7FFFFF -> 0xFF800000; overflow=inexact=1.
REQ-032 0x00000001 x 0x3F000000, RNE -> 0x00000000 (tie to even), underflow=inexact=1; RUP -> 0x00000001.
REQ-033 EXP_W=5, MAN_W=10: 0x4000 x 0x4200 -> 0x4600, flags 0.
REQ-034 Hold out_ready=0 for 5 cycles -> result stable, in_ready=0; pulse reset mid-NORM_A -> out_valid=0, next operation correct.
